bk8_serial_add: RTL and testbench

BK8_SERIAL_ADD -- requirements
Module: bk8_serial_add

---
 rtl/bk8_serial_add.sv | 212 +++++++++++++++++++++
 tb/tb_bk8_serial_add.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/bk8_serial_add.sv
// bk8_slice: 8-bit Brent-Kung adder slice with carry-in, carry-out and carry into bit 7.
// Latency: purely combinational, no state.
// Backpressure: none; output follows the inputs.
module bk8_slice (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_cin,
  output logic [7:0] o_sum,
  output logic       o_cout,
  output logic       o_c7
);

  // Bit-level generate/propagate
  logic [7:0] w_g;
  logic [7:0] w_p;

  // Carry-in is folded into bit 0's generate so the prefix tree yields
  // carries directly (group generate G[i:0] == carry into bit i+1).
  logic w_g0c;

  // Up-sweep: pairs
  logic w_g10, w_g32, w_p32, w_g54, w_p54, w_g76, w_p76;
  // Up-sweep: quads
  logic w_g30, w_g74, w_p74;
  // Up-sweep: full byte
  logic w_g70;
  // Down-sweep: fill in the remaining prefixes
  logic w_g50, w_g20, w_g40, w_g60;

  logic [7:0] w_c;

  assign w_g   = i_a & i_b;
  assign w_p   = i_a ^ i_b;
  assign w_g0c = w_g[0] | (w_p[0] & i_cin);

  assign w_g10 = w_g[1] | (w_p[1] & w_g0c);
  assign w_g32 = w_g[3] | (w_p[3] & w_g[2]);
  assign w_p32 = w_p[3] & w_p[2];
  assign w_g54 = w_g[5] | (w_p[5] & w_g[4]);
  assign w_p54 = w_p[5] & w_p[4];
  assign w_g76 = w_g[7] | (w_p[7] & w_g[6]);
  assign w_p76 = w_p[7] & w_p[6];

  assign w_g30 = w_g32 | (w_p32 & w_g10);
  assign w_g74 = w_g76 | (w_p76 & w_g54);
  assign w_p74 = w_p76 & w_p54;

  assign w_g70 = w_g74 | (w_p74 & w_g30);

  assign w_g50 = w_g54 | (w_p54 & w_g30);
  assign w_g20 = w_g[2] | (w_p[2] & w_g10);
  assign w_g40 = w_g[4] | (w_p[4] & w_g30);
  assign w_g60 = w_g[6] | (w_p[6] & w_g50);

  assign w_c = {w_g60, w_g50, w_g40, w_g30, w_g20, w_g10, w_g0c, i_cin};

  assign o_sum  = w_p ^ w_c;
  assign o_cout = w_g70;
  assign o_c7   = w_c[7];

endmodule

// bk8_serial_add: W-bit add (a+b+cin) computed one byte per cycle, LSB byte first, through one BK slice.
// Latency: out_valid rises NBYTES cycles after the accepting edge; one result per NBYTES+1 cycles back-to-back.
// Backpressure: result held in DONE while out_ready=0; in_ready low in BUSY and in DONE without out_ready.
module bk8_serial_add #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   a,
  input  logic [8*NBYTES-1:0]   b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            r_cout;
  logic            r_ovf;
  logic            r_out_valid;

  logic [7:0]      w_a_byte;
  logic [7:0]      w_b_byte;
  logic [7:0]      w_slice_sum;
  logic            w_slice_cout;
  logic            w_slice_c7;
  logic            w_in_ready;
  logic            w_last;

  // A new operand set can be taken when idle, or when the held result is
  // being consumed this very cycle (keeps back-to-back throughput).
  assign w_in_ready = (r_state == S_IDLE) ||
                      ((r_state == S_DONE) && out_ready);

  assign w_last = (r_idx == IW'(NBYTES - 1));

  // Select the current operand byte lanes from the latched operands
  always_comb begin
    w_a_byte = 8'h00;
    w_b_byte = 8'h00;
    for (int k = 0; k < NBYTES; k++) begin
      if (r_idx == IW'(k)) begin
        w_a_byte = r_a[8*k +: 8];
        w_b_byte = r_b[8*k +: 8];
      end
    end
  end

  bk8_slice u_slice (
    .i_a    (w_a_byte),
    .i_b    (w_b_byte),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout),
    .o_c7   (w_slice_c7)
  );

  // Control FSM plus datapath registers; outputs are registered so they
  // stay stable while a result waits for out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= S_BUSY;
          end
        end

        S_BUSY: begin
          // Write this byte of the sum; the slice carry feeds the next byte.
          for (int k = 0; k < NBYTES; k++) begin
            if (r_idx == IW'(k)) begin
              r_sum[8*k +: 8] <= w_slice_sum;
            end
          end
          r_carry <= w_slice_cout;
          if (w_last) begin
            r_cout      <= w_slice_cout;
            r_ovf       <= w_slice_c7 ^ w_slice_cout;
            r_out_valid <= 1'b1;
            r_idx       <= '0;
            r_state     <= S_DONE;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end

        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            if (in_valid) begin
              r_a     <= a;
              r_b     <= b;
              r_carry <= cin;
              r_idx   <= '0;
              r_state <= S_BUSY;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end

        default: begin
          r_state     <= S_IDLE;
          r_idx       <= '0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_bk8_serial_add.sv
// tb_bk8_serial_add: directed and randomised checks of the byte-serial adder.
// Latency: checks out_valid exactly 4 cycles after accept.
// Backpressure: exercises stalled results, back-to-back accepts and mid-op reset.
module tb_bk8_serial_add;

  localparam int NB = 4;
  localparam int W  = 8 * NB;
  localparam int NR = 1500;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          cin = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready;
  logic          out_valid;
  logic          cout;
  logic          ovf;
  logic [W-1:0]  sum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bk8_serial_add #(.NBYTES(NB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] f;
    f = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return {(x[W-1] == y[W-1]) && (f[W-1] != x[W-1]), f[W], f[W-1:0]};
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '1;
      1:       v = '0;
      2:       v = 32'h8000_0000;
      3:       v = 32'h7FFF_FFFF;
      default: v = $urandom;
    endcase
    return v;
  endfunction

  // Wait for out_valid after an accepting edge; returns cycles counted.
  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  // One operation from an idle state with out_ready held high.
  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic tc, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = ~ta; b = ~tb_v; cin = ~tc;
    wait_result(lat);
    chk({tag, " latency"}, 64'(lat), 64'd4);
    chk({tag, " sum"},  64'(sum),  64'(es));
    chk({tag, " cout"}, 64'(cout), 64'(ec));
    chk({tag, " ovf"},  64'(ovf),  64'(eo));
    @(posedge clk); #1;
    chk({tag, " out_valid drop"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    int lat;
    int cyc;
    int n_done;
    logic seen;
    logic [W+1:0] q_exp[$];
    logic [W+1:0] e;

    // Asynchronous reset with no clock edge in between
    #1 rst_n = 1'b0;
    #2;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst sum",       64'(sum),       64'd0);
    chk("rst cout",      64'(cout),      64'd0);
    chk("rst ovf",       64'(ovf),       64'd0);
    #19 rst_n = 1'b1;
    #1 chk("rst in_ready", 64'(in_ready), 64'd1);

    run_op("v1",  32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0);
    run_op("v2",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0);
    run_op("v3",  32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
    run_op("v4",  32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1);
    run_op("v5",  32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0);
    run_op("v6",  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("v7",  32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1);

    // Backpressure: hold result 10 cycles, then accept a new set in the release cycle
    @(negedge clk);
    a = 32'h1111_1111; b = 32'h2222_2222; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp latency", 64'(lat), 64'd4);
    a = 32'h0000_00FF; b = 32'h0000_0001; cin = 1'b0; in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      chk("bp out_valid", 64'(out_valid), 64'd1);
      chk("bp sum",       64'(sum),       64'h3333_3333);
      chk("bp in_ready",  64'(in_ready),  64'd0);
    end
    out_ready = 1'b1;
    #1 chk("bp release in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '1; b = '1;
    chk("bp b2b out_valid", 64'(out_valid), 64'd0);
    wait_result(lat);
    chk("bp b2b latency", 64'(lat), 64'd4);
    chk("bp b2b sum",  64'(sum),  64'h0000_0100);
    chk("bp b2b cout", 64'(cout), 64'd0);
    @(posedge clk); #1;

    // Reset pulsed during the second BUSY cycle discards the operation
    @(negedge clk);
    a = 32'h0101_0101; b = 32'h0101_0101; cin = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", 64'(out_valid), 64'd0);
    chk("mid rst sum",       64'(sum),       64'd0);
    chk("mid rst cout",      64'(cout),      64'd0);
    chk("mid rst ovf",       64'(ovf),       64'd0);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid rst no out_valid", 64'(seen), 64'd0);
    chk("mid rst in_ready", 64'(in_ready), 64'd1);
    run_op("post rst", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0);

    // Random valid/ready traffic against the reference model
    n_done = 0;
    cyc = 0;
    while (n_done < NR && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      a = pick();
      b = pick();
      cin = 1'($urandom_range(0, 1));
      #1;
      if (out_valid && out_ready) begin
        if (q_exp.size() == 0) begin
          chk("rnd spurious out_valid", 64'd1, 64'd0);
        end else begin
          e = q_exp.pop_front();
          chk("rnd result", 64'({ovf, cout, sum}), 64'(e));
          n_done++;
        end
      end
      if (in_valid && in_ready) q_exp.push_back(model(a, b, cin));
    end
    chk("rnd completed", 64'(n_done), 64'(NR));
    in_valid = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
